// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_pkg
// Description : Shared types and default widths for the program sequencer
//               with return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
package program_sequencer_pkg;

    // Default widths used by the top-level parameter list
    localparam int c_pc_w_default    = 8;
    localparam int c_tgt_w_default   = 4;
    localparam int c_stack_depth_def = 4;

    // Next-address source, listed from highest to lowest priority
    typedef enum logic [2:0] {
        NA_RESET = 3'd0,
        NA_HOLD  = 3'd1,
        NA_RET   = 3'd2,
        NA_CALL  = 3'd3,
        NA_JMP   = 3'd4,
        NA_JNZ   = 3'd5,
        NA_INC   = 3'd6
    } na_sel_t;

endpackage
`default_nettype wire

// File: rtl/ps_return_stack.sv
`default_nettype none
// ============================================================================
// Module      : ps_return_stack
// Description : LIFO return-address stack. Push is ignored when full, pop is
//               ignored when empty. top reads 0 while the stack is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ps_return_stack
    import program_sequencer_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         sync_reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    // sp counts occupied entries (0..DEPTH); the storage array is rounded up
    // to a power of two so that sp-derived indices are exactly index-wide.
    localparam int c_sp_w  = $clog2(DEPTH + 1);
    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_mem_n = 1 << c_idx_w;

    logic [W-1:0]       r_mem [c_mem_n];
    logic [c_sp_w-1:0]  r_sp;
    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == c_sp_w'(DEPTH));
    assign w_do_push = push && !w_full;
    assign w_do_pop  = pop && !w_empty;
    assign w_wr_idx  = c_idx_w'(r_sp);
    assign w_rd_idx  = c_idx_w'(r_sp - c_sp_w'(1));

    // Stack pointer: a simultaneous push and pop leaves the depth unchanged
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_sp <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_sp <= r_sp + c_sp_w'(1);
        end else if (w_do_pop && !w_do_push) begin
            r_sp <= r_sp - c_sp_w'(1);
        end
    end

    // Entry storage is not reset; a combined push/pop overwrites the top slot
    always_ff @(posedge clk) begin
        if (!sync_reset && w_do_push) begin
            r_mem[w_do_pop ? w_rd_idx : w_wr_idx] <= din;
        end
    end

    assign top   = w_empty ? '0 : r_mem[w_rd_idx];
    assign full  = w_full;
    assign empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/program_sequencer_stack.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_stack
// Description : Program sequencer. Selects the next program-memory address
//               from reset, hold, return, call, jumps or increment, registers
//               it as the PC and manages a return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer_stack
    import program_sequencer_pkg::*;
#(
    parameter int PC_W        = c_pc_w_default,
    parameter int TGT_W       = c_tgt_w_default,
    parameter int STACK_DEPTH = c_stack_depth_def
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [TGT_W-1:0] jmp_addr,
    input  logic             jmp,
    input  logic             jmp_nz,
    input  logic             dont_jmp,
    input  logic             call,
    input  logic             ret,
    input  logic             hold,
    output logic [PC_W-1:0]  pm_addr,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  from_PS,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    logic [PC_W-1:0] r_pc;
    logic            r_err;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_top;
    logic [PC_W-1:0] w_pm_addr;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_err_set;
    na_sel_t         w_sel;

    // Increment wraps naturally at the PC width; the same value is pushed
    assign w_pc_inc = r_pc + PC_W'(1);

    // Target places the jump field in the high bits of the address
    generate
        if (TGT_W == PC_W) begin : g_tgt_full
            assign w_target = jmp_addr;
        end else begin : g_tgt_pad
            assign w_target = {jmp_addr, {(PC_W - TGT_W){1'b0}}};
        end
    endgenerate

    // Priority decode of the control inputs into a single address source
    always_comb begin
        w_sel = NA_INC;
        if (sync_reset) begin
            w_sel = NA_RESET;
        end else if (hold) begin
            w_sel = NA_HOLD;
        end else if (ret) begin
            w_sel = NA_RET;
        end else if (call) begin
            w_sel = NA_CALL;
        end else if (jmp) begin
            w_sel = NA_JMP;
        end else if (jmp_nz && !dont_jmp) begin
            w_sel = NA_JNZ;
        end
    end

    // Next-address mux plus stack/err side effects of the chosen source;
    // a refused ret/call falls through to the increment and flags an error
    always_comb begin
        w_pm_addr = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        unique case (w_sel)
            NA_RESET: w_pm_addr = '0;
            NA_HOLD:  w_pm_addr = r_pc;
            NA_RET: begin
                if (!w_empty) begin
                    w_pm_addr = w_top;
                    w_pop     = 1'b1;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            NA_CALL: begin
                if (!w_full) begin
                    w_pm_addr = w_target;
                    w_push    = 1'b1;
                end else begin
                    w_err_set = 1'b1;
                end
            end
            NA_JMP, NA_JNZ: w_pm_addr = w_target;
            default: ;
        endcase
    end

    // PC follows the selected address on every edge, reset and hold included
    always_ff @(posedge clk) begin
        r_pc <= w_pm_addr;
    end

    // Sticky stack error, cleared only by reset
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    ps_return_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (w_push),
        .pop        (w_pop),
        .din        (w_pc_inc),
        .top        (w_top),
        .full       (w_full),
        .empty      (w_empty)
    );

    assign pm_addr     = w_pm_addr;
    assign pc          = r_pc;
    assign from_PS     = w_top;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign stack_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer_stack
// Description : Self-checking bench for program_sequencer_stack (defaults:
//               PC_W=8, TGT_W=4, STACK_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer_stack;

    typedef struct {
        logic       rst, hold, ret, call, jmp, jnz, dz;
        logic [3:0] addr;
        logic [7:0] pm;    // expected pm_addr this cycle == pc next cycle
        logic [7:0] top;   // expected from_PS after the edge
        logic       e, f, er;
    } vec_t;

    logic       clk = 1'b0;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, call, ret, hold;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic       stack_full, stack_empty, stack_err;

    int n_checks = 0;
    int n_errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    program_sequencer_stack #(
        .PC_W        (8),
        .TGT_W       (4),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .jmp_addr    (jmp_addr),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .call        (call),
        .ret         (ret),
        .hold        (hold),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .from_PS     (from_PS),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    function automatic vec_t mkv(input logic rst, hold_i, ret_i, call_i, jmp_i, jnz_i, dz_i,
                                 input logic [3:0] a, input logic [7:0] pm_e, top_e,
                                 input logic e, f, er);
        vec_t v;
        v.rst = rst; v.hold = hold_i; v.ret = ret_i; v.call = call_i;
        v.jmp = jmp_i; v.jnz = jnz_i; v.dz = dz_i; v.addr = a;
        v.pm = pm_e; v.top = top_e; v.e = e; v.f = f; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, check pm_addr before the rising edge,
    // then check registered outputs just after it.
    task automatic cyc(input vec_t v, input string tag);
        sync_reset = v.rst; hold = v.hold; ret = v.ret; call = v.call;
        jmp = v.jmp; jmp_nz = v.jnz; dont_jmp = v.dz; jmp_addr = v.addr;
        #1;
        chk({tag, " pm_addr"}, 32'(pm_addr), 32'(v.pm));
        @(posedge clk);
        #1;
        chk({tag, " pc"},          32'(pc),          32'(v.pm));
        chk({tag, " from_PS"},     32'(from_PS),     32'(v.top));
        chk({tag, " stack_empty"}, 32'(stack_empty), 32'(v.e));
        chk({tag, " stack_full"},  32'(stack_full),  32'(v.f));
        chk({tag, " stack_err"},   32'(stack_err),   32'(v.er));
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        cyc(mkv(1,0,0,0,0,0,0, 4'h0, 8'h00, 8'h00, 1,0,0), tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sync_reset = 1'b1; jmp = 0; jmp_nz = 0; dont_jmp = 0;
        call = 0; ret = 0; hold = 0; jmp_addr = 4'h0;

        //          rst hld ret cal jmp jnz dz addr   pm     top   e f er
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h01, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h02, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h03, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h04, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h05, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,0,1,0,0, 4'hA, 8'hA0, 8'h00, 1,0,0)); // jmp at 0x05
        tbl.push_back(mkv(0,0,0,0,0,1,1, 4'h3, 8'hA1, 8'h00, 1,0,0)); // jnz suppressed
        tbl.push_back(mkv(0,0,0,0,0,1,0, 4'h1, 8'h10, 8'h00, 1,0,0)); // jnz taken
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h11, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h12, 8'h00, 1,0,0));
        tbl.push_back(mkv(0,0,0,1,0,0,0, 4'h3, 8'h30, 8'h13, 0,0,0)); // call at 0x12
        tbl.push_back(mkv(0,0,0,0,0,0,0, 4'h0, 8'h31, 8'h13, 0,0,0));
        tbl.push_back(mkv(0,0,1,0,0,0,0, 4'h0, 8'h13, 8'h00, 1,0,0)); // ret
        tbl.push_back(mkv(0,1,0,0,1,0,0, 4'h7, 8'h13, 8'h00, 1,0,0)); // hold+jmp
        tbl.push_back(mkv(0,0,1,1,0,0,0, 4'h5, 8'h14, 8'h00, 1,0,1)); // ret wins, underflow
        tbl.push_back(mkv(0,1,0,1,0,0,0, 4'h9, 8'h14, 8'h00, 1,0,1)); // hold blocks push
        tbl.push_back(mkv(0,0,0,0,1,1,0, 4'h2, 8'h20, 8'h00, 1,0,1));
        tbl.push_back(mkv(1,0,0,1,0,0,0, 4'h9, 8'h00, 8'h00, 1,0,0)); // reset during call
        tbl.push_back(mkv(0,0,0,1,1,0,0, 4'h6, 8'h60, 8'h01, 0,0,0)); // call beats jmp
        tbl.push_back(mkv(1,0,0,0,0,0,0, 4'h0, 8'h00, 8'h00, 1,0,0)); // reset drops stack

        @(negedge clk);
        do_reset("reset");
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Free-run across the 0xFF -> 0x00 wrap
        do_reset("run reset");
        for (int i = 0; i < 257; i++) begin
            cyc(mkv(0,0,0,0,0,0,0, 4'h0, 8'(i + 1), 8'h00, 1,0,0), $sformatf("run[%0d]", i));
        end

        // Overflow on the fifth call, then LIFO returns
        do_reset("ovf reset");
        cyc(mkv(0,0,0,1,0,0,0, 4'h1, 8'h10, 8'h01, 0,0,0), "ovf call1");
        cyc(mkv(0,0,0,1,0,0,0, 4'h2, 8'h20, 8'h11, 0,0,0), "ovf call2");
        cyc(mkv(0,0,0,1,0,0,0, 4'h3, 8'h30, 8'h21, 0,0,0), "ovf call3");
        cyc(mkv(0,0,0,1,0,0,0, 4'h4, 8'h40, 8'h31, 0,1,0), "ovf call4");
        cyc(mkv(0,0,0,1,0,0,0, 4'h5, 8'h41, 8'h31, 0,1,1), "ovf call5");
        cyc(mkv(0,0,1,0,0,0,0, 4'h0, 8'h31, 8'h21, 0,0,1), "ovf ret1");
        cyc(mkv(0,0,1,0,0,0,0, 4'h0, 8'h21, 8'h11, 0,0,1), "ovf ret2");
        cyc(mkv(0,0,1,0,0,0,0, 4'h0, 8'h11, 8'h01, 0,0,1), "ovf ret3");
        cyc(mkv(0,0,1,0,0,0,0, 4'h0, 8'h01, 8'h00, 1,0,1), "ovf ret4");

        // Underflow at 0xFF wraps to 0x00, reset clears the flag
        do_reset("unf reset");
        cyc(mkv(0,0,0,0,1,0,0, 4'hF, 8'hF0, 8'h00, 1,0,0), "unf jmp");
        for (int i = 1; i < 16; i++) begin
            cyc(mkv(0,0,0,0,0,0,0, 4'h0, 8'(8'hF0 + i), 8'h00, 1,0,0), $sformatf("unf inc[%0d]", i));
        end
        cyc(mkv(0,0,1,0,0,0,0, 4'h0, 8'h00, 8'h00, 1,0,1), "unf ret");
        do_reset("unf clear");

        // ret+call with a single entry: pop only
        cyc(mkv(0,0,0,1,0,0,0, 4'h2, 8'h20, 8'h01, 0,0,0), "rc call");
        cyc(mkv(0,0,1,1,0,0,0, 4'h5, 8'h01, 8'h00, 1,0,0), "rc ret+call");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_sequencer_stack.md
# program_sequencer_stack

Parametrised next-generation program sequencer for the small microcode processor. It computes the next program-memory address each cycle from the current PC and the decoded control inputs, and registers it as the PC. It adds a return-address stack (call/return) and a fetch-hold input to the existing unconditional and conditional jumps. It sits between the instruction decoder and the program memory; `from_PS` feeds the data-path source mux.

## Interface
- `PC_W`, default 8 — program counter / program-memory address width.
- `TGT_W`, default 4 — jump-target field width; requires `TGT_W <= PC_W`.
- `STACK_DEPTH`, default 4 — return-stack entries; requires `STACK_DEPTH >= 1`.
- `clk`  in  1  — single clock, all state changes on the rising edge.
- `sync_reset`  in  1  — reset, synchronous and active-high.
- `jmp_addr`  in  `TGT_W`  — target field. Target = `{jmp_addr, (PC_W-TGT_W) zeros}`.
- `jmp`  in  1  — unconditional jump.
- `jmp_nz`  in  1  — conditional jump.
- `dont_jmp`  in  1  — zero flag; suppresses `jmp_nz` when 1.
- `call`  in  1  — push return address (`pc+1`), jump to target.
- `ret`  in  1  — pop return address, jump to it.
- `hold`  in  1  — refetch the current address.
- `pm_addr`  out  `PC_W`  — next address, combinational.
- `pc`  out  `PC_W`  — registered current address.
- `from_PS`  out  `PC_W`  — top of return stack; 0 when the stack is empty.
- `stack_full`, `stack_empty`  out  1  — stack occupancy.
- `stack_err`  out  1  — sticky overflow/underflow flag.

## Operation
- `pm_addr` select, highest priority first:
  - `sync_reset` → 0.
  - `hold` → `pc`.
  - `ret` → if the stack is non-empty, top of stack (pop). If empty, `pc+1` and set `stack_err`.
  - `call` → if the stack is not full, target (push `pc+1`). If full, `pc+1`, no push, set `stack_err`.
  - `jmp` → target.
  - `jmp_nz && !dont_jmp` → target.
  - Otherwise → `pc+1`.
- Increment is modulo 2^`PC_W`: all-ones wraps to 0. The pushed return address wraps the same way.
- Lower-priority requests in the same cycle are ignored. Example: `call` with `ret` → `ret` only, no push.
- `hold` suppresses all push/pop and flag updates.
- The stack is a LIFO with a pointer `sp` in 0..`STACK_DEPTH`. `stack_empty` = (`sp`==0); `stack_full` = (`sp`==`STACK_DEPTH`).
- `stack_err` stays at 1 until `sync_reset`. It has no effect on sequencing.
- Reset: `sp`=0, `stack_err`=0, entries are don't-care, `pm_addr`=0 while reset is asserted.

## Timing
- `pm_addr` is a combinational function of the inputs, `pc`, and stack state, all in the same cycle.
- `pc` <= `pm_addr` on every edge, including during reset and hold. `pc` is therefore always `pm_addr` delayed one cycle.
- First edge with `sync_reset`=1: `pc`=0, `sp`=0, `stack_err`=0.
- Jump latency: a control input asserted in cycle n appears on `pm_addr` in cycle n and on `pc` in cycle n+1. No delay slot.
- Push, pop, and `stack_err` set take effect at the same edge that loads `pc`. `from_PS` reflects the new top in the next cycle.
- Reset mid-call/ret: reset wins; the pending push/pop is discarded.

## Structure
- Package `program_sequencer_pkg` holds:
  - the next-address-select enum `na_sel_t` (`NA_RESET`, `NA_HOLD`, `NA_RET`, `NA_CALL`, `NA_JMP`, `NA_JNZ`, `NA_INC`);
  - default width constants.
- Sub-module `ps_return_stack`:
  - parameters `W`, `DEPTH`;
  - ports: `push`, `pop`, `din`, `top`, `full`, `empty`, `sync_reset`;
  - ignores `push` when full and `pop` when empty.
- The top level contains the priority decoder, the `pc` register, the error flag, and the target formation.

## Test plan
- Reset then free-run, `PC_W`=8: `pc` runs 0,1,2,…,0xFF,0x00. `pm_addr` leads `pc` by one cycle.
- `jmp`=1, `jmp_addr`=4'hA at `pc`=0x05: `pm_addr`=0xA0 that cycle, `pc`=0xA0 next cycle. Repeat with `jmp_nz`=1 and `dont_jmp`=1: `pc`=0x06.
- Call/return at `pc`=0x12:
  - `call` with `jmp_addr`=4'h3 → `pc`=0x30, `from_PS`=0x13.
  - Two cycles later `ret` → `pc`=0x13, `stack_empty`=1.
- Overflow, `STACK_DEPTH`=4: five consecutive calls. The fifth is not taken (`pc+1`), `stack_err`=1, `stack_full`=1. Four rets then return in LIFO order.
- Underflow: `ret` with an empty stack at `pc`=0xFF → `pc`=0x00 and `stack_err`=1. `sync_reset` clears it.
- Simultaneous events:
  - `hold`+`jmp` → `pc` unchanged.
  - `ret`+`call` with depth 1 → pop only, no push.
  - `sync_reset` during `call` → `pc`=0, `sp`=0.
